// File: rtl/mips_multicycle_control.sv
// Control FSM for the multicycle MIPS core: decodes the IR opcode/funct and
// sequences fetch, decode, execute, memory and write-back, driving every datapath enable and select.
module mips_multicycle_control #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] pc_src,
    output logic [3:0] alu_op,
    output logic       illegal_op
);

    localparam int unsigned CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    // ALU control encodings shared with the ALU
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] SRCB_REG  = 3'd0;
    localparam logic [2:0] SRCB_FOUR = 3'd1;
    localparam logic [2:0] SRCB_SEXT = 3'd2;
    localparam logic [2:0] SRCB_SHL2 = 3'd3;
    localparam logic [2:0] SRCB_ZEXT = 3'd4;

    localparam logic [2:0] PCS_ALU    = 3'd0;
    localparam logic [2:0] PCS_ALUOUT = 3'd1;
    localparam logic [2:0] PCS_JUMP   = 3'd2;
    localparam logic [2:0] PCS_REGA   = 3'd3;
    localparam logic [2:0] PCS_VECTOR = 3'd4;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JAL      = 4'd11,
        S_JR       = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic               zext_q, zext_d;
    logic               dst_rd_q, dst_rd_d;
    logic               store_q, store_d;
    logic               bne_q, bne_d;

    state_e             dec_state;
    logic [3:0]         dec_alu_op;
    logic               dec_zext;
    logic               dec_dst_rd;
    logic               dec_store;
    logic               dec_bne;
    logic               wait_last;

    assign wait_last = (wait_cnt_q == CNT_W'(MEM_WAIT - 1));

    // Instruction decode; only consumed in DECODE, where the IR is stable
    always_comb begin
        dec_state  = S_ILLEGAL;
        dec_alu_op = ALU_ADD;
        dec_zext   = 1'b0;
        dec_dst_rd = 1'b0;
        dec_store  = 1'b0;
        dec_bne    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_dst_rd = 1'b1;
                dec_state  = S_EXEC_R;
                case (funct)
                    FN_ADD:  dec_alu_op = ALU_ADD;
                    FN_SUB:  dec_alu_op = ALU_SUB;
                    FN_AND:  dec_alu_op = ALU_AND;
                    FN_OR:   dec_alu_op = ALU_OR;
                    FN_XOR:  dec_alu_op = ALU_XOR;
                    FN_NOR:  dec_alu_op = ALU_NOR;
                    FN_SLT:  dec_alu_op = ALU_SLT;
                    FN_SLL:  dec_alu_op = ALU_SLL;
                    FN_SRL:  dec_alu_op = ALU_SRL;
                    FN_SRA:  dec_alu_op = ALU_SRA;
                    FN_JR:   dec_state  = S_JR;
                    default: dec_state  = S_ILLEGAL;
                endcase
            end
            OP_LW:   dec_state = S_MEM_ADDR;
            OP_SW: begin
                dec_state = S_MEM_ADDR;
                dec_store = 1'b1;
            end
            OP_ADDI: dec_state = S_EXEC_I;
            OP_SLTI: begin
                dec_state  = S_EXEC_I;
                dec_alu_op = ALU_SLT;
            end
            OP_ANDI: begin
                dec_state  = S_EXEC_I;
                dec_alu_op = ALU_AND;
                dec_zext   = 1'b1;
            end
            OP_ORI: begin
                dec_state  = S_EXEC_I;
                dec_alu_op = ALU_OR;
                dec_zext   = 1'b1;
            end
            OP_XORI: begin
                dec_state  = S_EXEC_I;
                dec_alu_op = ALU_XOR;
                dec_zext   = 1'b1;
            end
            OP_BEQ:  dec_state = S_BRANCH;
            OP_BNE: begin
                dec_state = S_BRANCH;
                dec_bne   = 1'b1;
            end
            OP_J:    dec_state = S_JUMP;
            OP_JAL:  dec_state = S_JAL;
            default: dec_state = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            alu_op_q   <= ALU_ADD;
            zext_q     <= 1'b0;
            dst_rd_q   <= 1'b0;
            store_q    <= 1'b0;
            bne_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            alu_op_q   <= alu_op_d;
            zext_q     <= zext_d;
            dst_rd_q   <= dst_rd_d;
            store_q    <= store_d;
            bne_q      <= bne_d;
        end
    end

    // Next state and Moore outputs; BRANCH pc_write is the one zero-dependent output
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        alu_op_d   = alu_op_q;
        zext_d     = zext_q;
        dst_rd_d   = dst_rd_q;
        store_d    = store_q;
        bne_d      = bne_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCS_ALU;
        alu_op     = ALU_ADD;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                if (wait_last) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_DECODE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_SHL2;
                state_d   = dec_state;
                alu_op_d  = dec_alu_op;
                zext_d    = dec_zext;
                dst_rd_d  = dec_dst_rd;
                store_d   = dec_store;
                bne_d     = dec_bne;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SEXT;
                state_d   = store_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord = 1'b1;
                if (wait_last) begin
                    wait_cnt_d = '0;
                    state_d    = S_MEM_WB;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_MEM_WB: begin
                mem_to_reg = 2'd1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (wait_last) begin
                    wait_cnt_d = '0;
                    state_d    = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = alu_op_q;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = zext_q ? SRCB_ZEXT : SRCB_SEXT;
                alu_op    = alu_op_q;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = dst_rd_q ? 2'd1 : 2'd0;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCS_ALUOUT;
                pc_write  = zero ^ bne_q;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PCS_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                pc_src     = PCS_JUMP;
                pc_write   = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                pc_src   = PCS_REGA;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                pc_src     = PCS_VECTOR;
                pc_write   = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = S_FETCH;
            end
        endcase

        // Reset holds every write strobe low even though the state decode is live
        if (!rstb) begin
            pc_write   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule
